// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular AXI-stream arbiter.
// A requester keeps its grant from the first to the last beat of a packet, so packets never
// interleave. One registered output stage carries the beat and the index of its source port.
// When MAX_BEATS is non-zero, a grant ends after that many beats with down_last forced high;
// the rest of the packet then competes again as a new packet.
module axis_packet_arbiter #(
  parameter int unsigned NB_PORTS   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned MAX_BEATS  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NB_PORTS-1:0]            up_valid,
  output logic [NB_PORTS-1:0]            up_ready,
  input  logic [NB_PORTS*DATA_WIDTH-1:0] up_data,
  input  logic [NB_PORTS-1:0]            up_last,
  input  logic                           down_ready,
  output logic                           down_valid,
  output logic [DATA_WIDTH-1:0]          down_data,
  output logic                           down_last,
  output logic [ID_WIDTH-1:0]            down_id,
  output logic                           busy
);

  localparam logic [15:0]         MaxBeatsW = 16'(MAX_BEATS);
  localparam logic [ID_WIDTH-1:0] PrevRst   = ID_WIDTH'(NB_PORTS - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     prev_q, prev_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    down_valid_q, down_valid_d;
  logic [DATA_WIDTH-1:0]   down_data_q, down_data_d;
  logic                    down_last_q, down_last_d;
  logic [ID_WIDTH-1:0]     down_id_q, down_id_d;

  logic                    adv;
  logic                    gnt_valid;
  logic                    gnt_last;
  logic [DATA_WIDTH-1:0]   gnt_data;
  logic                    accept;
  logic                    limit_hit;
  logic                    pkt_end;
  logic [ID_WIDTH-1:0]     winner;

  // Output stage can take a new beat when empty or draining this cycle.
  assign adv       = down_ready | ~down_valid_q;
  assign accept    = (state_q == StBusy) & gnt_valid & adv;
  assign limit_hit = accept & (MAX_BEATS != 0) & ((cnt_q + 16'd1) == MaxBeatsW);
  assign pkt_end   = gnt_last | limit_hit;

  // Mux the granted port's valid/last/data.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NB_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        gnt_valid = up_valid[i];
        gnt_last  = up_last[i];
        gnt_data  = up_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pick: first requester at or after prev+1, wrapping.
  always_comb begin
    logic                found;
    logic [ID_WIDTH-1:0] idx;
    winner = prev_q;
    found  = 1'b0;
    for (int k = 1; k <= NB_PORTS; k++) begin
      idx = ID_WIDTH'((int'(prev_q) + k) % int'(NB_PORTS));
      if (!found && up_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State register plus grant bookkeeping and output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      prev_q       <= PrevRst;
      cnt_q        <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_last_q  <= 1'b0;
      down_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_last_q  <= down_last_d;
      down_id_q    <= down_id_d;
    end
  end

  // Next state: grant on any request in idle, release on the packet's (or segment's) end.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|up_valid) begin
          state_d = StBusy;
          grant_d = winner;
          prev_d  = winner;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        // A granted port going quiet mid-packet keeps the grant.
        if (accept) begin
          cnt_d = cnt_q + 16'd1;
          if (pkt_end) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: ready only to the granted port, output stage loads or holds on adv.
  always_comb begin
    up_ready     = '0;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_last_d  = down_last_q;
    down_id_d    = down_id_q;
    for (int i = 0; i < NB_PORTS; i++) begin
      if ((state_q == StBusy) && (grant_q == ID_WIDTH'(i))) begin
        up_ready[i] = adv;
      end
    end
    if (adv) begin
      down_valid_d = accept;
      if (accept) begin
        down_data_d = gnt_data;
        down_last_d = pkt_end;
        down_id_d   = grant_q;
      end
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_last  = down_last_q;
  assign down_id    = down_id_q;
  assign busy       = (state_q == StBusy);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter (4 ports, 8-bit data, 4-beat grant limit).
// Per-port source queues feed the upstream side; every beat the DUT should emit is pushed to a
// scoreboard queue and checked in order when it completes downstream.
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] up_valid;
  logic [NP-1:0] up_ready;
  logic [NP*DW-1:0] up_data;
  logic [NP-1:0] up_last;
  logic          down_ready;
  logic          down_valid;
  logic [DW-1:0] down_data;
  logic          down_last;
  logic [1:0]    down_id;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Source queues hold {last, data}; scoreboard holds {id, last, data}.
  logic [8:0]    src [NP][$];
  logic [NP-1:0] src_en;
  logic [10:0]   exp_q [$];
  logic [12:0]   pat;

  axis_packet_arbiter #(
    .NB_PORTS  (4),
    .DATA_WIDTH(8),
    .ID_WIDTH  (2),
    .MAX_BEATS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_last   (up_last),
    .down_ready(down_ready),
    .down_valid(down_valid),
    .down_data (down_data),
    .down_last (down_last),
    .down_id   (down_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src_push(input logic [1:0] port, input logic [7:0] d, input logic l);
    src[port].push_back({l, d});
  endtask

  task automatic exp_push(input logic [1:0] id, input logic [7:0] d, input logic l);
    exp_q.push_back({id, l, d});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || down_valid) && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // Consume a source beat on each upstream handshake (pre-edge values).
  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (up_valid[i] && up_ready[i] && src[i].size() != 0) begin
        void'(src[i].pop_front());
      end
    end
  end

  // Present each source's head beat, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (src_en[i] && src[i].size() != 0) begin
        up_valid[i] = 1'b1;
        {up_last[i], up_data[i*DW +: DW]} = src[i][0];
      end else begin
        up_valid[i] = 1'b0;
        up_last[i]  = 1'b0;
        up_data[i*DW +: DW] = '0;
      end
    end
  end

  // Scoreboard: every completed downstream beat must match the next expected one.
  always @(negedge clk) begin
    logic [10:0] e;
    if (down_valid === 1'b1 && down_ready === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 32'({down_id, down_last, down_data}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    down_ready = 1'b1;
    src_en     = '1;
    up_valid   = '0;
    up_last    = '0;
    up_data    = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_down_data", 32'(down_data), 32'd0);
    check("rst_down_last", 32'(down_last), 32'd0);
    check("rst_down_id", 32'(down_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd0);

    // Single-port packet on port 2; latency 2, busy cycles 1..3.
    src_push(2, 8'hA1, 0); src_push(2, 8'hA2, 0); src_push(2, 8'hA3, 1);
    exp_push(2, 8'hA1, 0); exp_push(2, 8'hA2, 0); exp_push(2, 8'hA3, 1);
    tick();
    check("t1_c1_busy", 32'(busy), 32'd1);
    check("t1_c1_ready", 32'(up_ready), 32'b0100);
    check("t1_c1_dvalid", 32'(down_valid), 32'd0);
    tick();
    check("t1_c2_dvalid", 32'(down_valid), 32'd1);
    check("t1_c2_data", 32'(down_data), 32'hA1);
    check("t1_c2_id", 32'(down_id), 32'd2);
    tick();
    check("t1_c3_busy", 32'(busy), 32'd1);
    tick();
    check("t1_c4_last", 32'(down_last), 32'd1);
    check("t1_c4_busy", 32'(busy), 32'd0);
    tick();
    check("t1_c5_dvalid", 32'(down_valid), 32'd0);
    drain("t1_drain");

    // Contention: ports 0 and 1 alternate 2-beat packets with one bubble each.
    src_push(0, 8'hB0, 0); src_push(0, 8'hB1, 1); src_push(0, 8'hB2, 0); src_push(0, 8'hB3, 1);
    src_push(1, 8'hC0, 0); src_push(1, 8'hC1, 1); src_push(1, 8'hC2, 0); src_push(1, 8'hC3, 1);
    exp_push(0, 8'hB0, 0); exp_push(0, 8'hB1, 1);
    exp_push(1, 8'hC0, 0); exp_push(1, 8'hC1, 1);
    exp_push(0, 8'hB2, 0); exp_push(0, 8'hB3, 1);
    exp_push(1, 8'hC2, 0); exp_push(1, 8'hC3, 1);
    for (int c = 0; c < 13; c++) begin
      tick();
      pat[c] = down_valid;
    end
    check("t2_valid_pattern", 32'(pat), 32'hDB6);
    drain("t2_drain");

    // Backpressure during a 4-beat packet on port 2.
    for (int b = 0; b < 4; b++) begin
      src_push(2, 8'(8'hD0 + b), (b == 3));
      exp_push(2, 8'(8'hD0 + b), (b == 3));
    end
    tick();
    tick();
    down_ready = 1'b0;
    #1;
    check("t3_c2_ready", 32'(up_ready), 32'd0);
    tick();
    check("t3_c3_dvalid", 32'(down_valid), 32'd1);
    check("t3_c3_data", 32'(down_data), 32'hD0);
    check("t3_c3_last", 32'(down_last), 32'd0);
    check("t3_c3_id", 32'(down_id), 32'd2);
    check("t3_c3_ready", 32'(up_ready), 32'd0);
    tick();
    down_ready = 1'b1;
    #1;
    check("t3_c4_data", 32'(down_data), 32'hD0);
    check("t3_c4_ready", 32'(up_ready), 32'b0100);
    drain("t3_drain");

    // Beat limit 4 on a 6-beat packet from port 3.
    for (int b = 1; b <= 6; b++) begin
      src_push(3, 8'(8'hE0 + b), (b == 6));
      exp_push(3, 8'(8'hE0 + b), (b == 4 || b == 6));
    end
    repeat (5) tick();
    check("t4_c5_busy", 32'(busy), 32'd0);
    check("t4_c5_data", 32'(down_data), 32'hE4);
    check("t4_c5_last", 32'(down_last), 32'd1);
    check("t4_c5_id", 32'(down_id), 32'd3);
    drain("t4_drain");

    // Reset during beat 2 of a 5-beat packet on port 1.
    for (int b = 1; b <= 5; b++) src_push(1, 8'(8'hF0 + b), (b == 5));
    exp_push(1, 8'hF1, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_dvalid", 32'(down_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(up_ready), 32'd0);
    rst = 1'b0;
    src[1].delete();
    src_push(0, 8'h60, 0); src_push(0, 8'h61, 1);
    src_push(1, 8'h70, 1);
    exp_push(0, 8'h60, 0); exp_push(0, 8'h61, 1);
    exp_push(1, 8'h70, 1);
    tick();
    check("t5_regrant", 32'(up_ready), 32'b0001);
    drain("t5_drain");

    // Granted port 1 goes quiet for 3 cycles while port 0 requests.
    for (int b = 0; b < 4; b++) begin
      src_push(1, 8'(8'h80 + b), (b == 3));
      exp_push(1, 8'(8'h80 + b), (b == 3));
    end
    tick();
    tick();
    src_en[1] = 1'b0;
    src_push(0, 8'h90, 0); src_push(0, 8'h91, 1);
    exp_push(0, 8'h90, 0); exp_push(0, 8'h91, 1);
    for (int c = 3; c <= 5; c++) begin
      tick();
      if (c == 5) src_en[1] = 1'b1;
      check("t6_busy", 32'(busy), 32'd1);
      check("t6_ready", 32'(up_ready), 32'b0010);
    end
    drain("t6_drain");

    check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin, packet-granular arbiter that shares one AXI-stream datapath between NB_PORTS upstream requesters, such as a single axis_deserializer or DMA write channel. A grant is held from the first beat of a packet until its last beat, so packets are never interleaved. The block drives one registered output stage with the source index attached. An optional beat limit bounds how long one requester can hold the shared resource.

## Interface
Parameters:
- NB_PORTS, 4, number of upstream requesters (2..16)
- DATA_WIDTH, 8, width of one data word
- ID_WIDTH, 2, width of down_id; 2**ID_WIDTH >= NB_PORTS
- MAX_BEATS, 0, grant beat limit; 0 means unlimited, otherwise 1..65535

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- up_valid  in  NB_PORTS  per-port valid
- up_ready  out  NB_PORTS  per-port ready
- up_data  in  NB_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- up_last  in  NB_PORTS  per-port end of packet
- down_ready  in  1  downstream ready
- down_valid  out  1  registered output valid
- down_data  out  DATA_WIDTH  registered output data
- down_last  out  1  registered end of packet, possibly forced by the beat limit
- down_id  out  ID_WIDTH  index of the port that sourced the current output beat
- busy  out  1  high while a grant is held (state BUSY)

## Operation
- Transfer rules:
  - Upstream beat on port i accepted when up_valid[i] & up_ready[i].
  - Downstream beat completes when down_valid & down_ready.
  - Output stage may load when adv = down_ready | ~down_valid.
- State machine, IDLE / BUSY:
  - IDLE: all up_ready low. If any up_valid is high, select a winner and go to BUSY with grant = winner. Otherwise stay in IDLE.
  - BUSY: up_ready[grant] = adv; all other up_ready low.
  - On an accepted beat that is the packet end, return to IDLE. Packet end means up_last[grant], or the beat count reaching MAX_BEATS when MAX_BEATS != 0.
  - Granted port dropping up_valid mid-packet does not release the grant. The arbiter waits indefinitely.
- Round-robin selection:
  - Search starts at (prev + 1) mod NB_PORTS, ascending with wrap.
  - prev = index of the last grant; reset value NB_PORTS-1, so port 0 wins first after reset.
  - prev updates on entry to BUSY.
- Beat counter:
  - 16 bits, cleared on entry to BUSY, incremented on each accepted beat.
  - When an accepted beat is beat MAX_BEATS, down_last is forced to 1 for that beat and the grant is released.
  - The rest of that source packet re-arbitrates as a new packet.
- Output stage, when adv:
  - Accepted beat: down_valid <= 1, down_data <= up_data slice, down_last <= up_last[grant] | limit_hit, down_id <= grant.
  - No accepted beat: down_valid <= 0.
  - When ~adv, all output registers hold their value.

## Timing
- Reset values: down_valid 0, down_data 0, down_last 0, down_id 0, busy 0, up_ready all 0, state IDLE, prev NB_PORTS-1, counter 0.
- Reset asserted mid-packet: outputs return to reset values on the next edge. The in-flight beat is discarded and the packet is not completed.
- Latency, up_valid rising in IDLE to down_valid: 2 cycles.
  - Cycle 0: arbitrate.
  - Cycle 1: BUSY, first beat accepted.
  - Cycle 2: beat on output.
- Throughput in BUSY: one beat per cycle while down_ready stays high.
- Packet gap: one idle arbitration cycle between packets, i.e. one bubble on down_valid.
- Backpressure: when down_ready is low with down_valid high, down_data, down_last and down_id stay stable and up_ready[grant] is low in the same cycle.
- Single-beat packet (up_last on the first beat): BUSY lasts one cycle when not stalled.
- Requests arriving during BUSY wait for the return to IDLE. A request withdrawn before arbitration is never granted.

## Test plan
- Single-port packet: port 2 sends 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3, down_ready=1 → down_valid on cycles 2..4, down_id=2, down_last only on 0xA3, busy high for cycles 1..3.
- Contention: ports 0 and 1 each send continuous 2-beat packets → output order p0, p1, p0, p1, one bubble between packets, never interleaved.
- Backpressure: down_ready toggles 1,0,0,1 during a 4-beat packet → all 4 beats delivered exactly once and in order; outputs stable while stalled; no up_ready on the stalled cycles.
- Beat limit: MAX_BEATS=4, port 3 sends 6 beats with last on beat 6 → beat 4 has down_last=1, then re-arbitration, then beats 5-6 with down_last on beat 6, both segments with down_id=3.
- Reset mid-packet: rst for 1 cycle during beat 2 of 5 → down_valid=0 and busy=0 next cycle; the next grant goes to port 0 if it is requesting.
- Valid gap: granted port 1 drops up_valid for 3 cycles mid-packet while port 0 requests → grant stays on port 1 until its last beat.
